param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Adds configurable width and modulus, up/down direction, count enable, synchronous clear, parallel load, and a choice of wrap or saturate at the range limits.
- Also provides boundary flags and registered event pulses.
- Used as a general event, timer or index counter in datapath and testbench infrastructure; a single clock domain.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- MOD_VAL, 16: modulus. The count range is 0..MOD_VAL-1. Legal range is 2..2^WIDTH; elaboration-time error if outside.
- INIT_VAL, 0: value of count on reset and on clr. Must be less than MOD_VAL.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear to INIT_VAL
- en  in  1  count enable
- up_dn  in  1  direction: 1 = increment, 0 = decrement
- sat_mode  in  1  boundary mode: 1 = saturate at the limit, 0 = wrap modulo MOD_VAL
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value to load
- count  out  WIDTH  registered count
- at_max  out  1  combinational; high when count == MOD_VAL-1
- at_zero  out  1  combinational; high when count == 0
- wrap_p  out  1  registered one-cycle pulse: a wrap happened on the previous edge
- sat_p  out  1  registered one-cycle pulse: a step was blocked at a limit on the previous edge
- evt_cnt  out  16  wrap event counter (see Optional Feature)

Behaviour:
- Reset: while reset_n is low, asynchronously set count = INIT_VAL, wrap_p = 0, sat_p = 0, evt_cnt = 0. Leaving reset takes effect on the first rising clk edge after reset_n goes high.
- Priority on each rising edge, highest first: clr, then load, then en, then hold.
- clr: count <= INIT_VAL; wrap_p <= 0; sat_p <= 0. Takes precedence over load and en in the same cycle.
- load: count <= load_val when load_val <= MOD_VAL-1; otherwise count <= MOD_VAL-1 (clamped). A load never generates wrap_p or sat_p.
- en with up_dn = 1:
  - count < MOD_VAL-1: count <= count+1.
  - count == MOD_VAL-1 and sat_mode = 0: count <= 0, wrap_p <= 1.
  - count == MOD_VAL-1 and sat_mode = 1: count holds, sat_p <= 1.
- en with up_dn = 0:
  - count > 0: count <= count-1.
  - count == 0 and sat_mode = 0: count <= MOD_VAL-1, wrap_p <= 1.
  - count == 0 and sat_mode = 1: count holds, sat_p <= 1.
- Pulse rules: wrap_p and sat_p are 0 in every cycle that does not meet one of the conditions above. Each is high for exactly one cycle per event and is never high at the same time as the other.
- Timing: latency from the en edge to the count update is 1 cycle. wrap_p and sat_p rise on the same edge that performs, or blocks, the step.
- Arithmetic: all comparisons against MOD_VAL-1 are at WIDTH bits. When MOD_VAL == 2^WIDTH, natural overflow must give the same result as the explicit wrap.
- Live mode changes: up_dn and sat_mode may change on any cycle. They are sampled only on edges where en is the active operation.
- en low and no clr/load: count and evt_cnt hold; the pulses drop to 0.

Optional Feature:
- Macro: COUNTER_EVT_CNT_EN.
- Defined:
  - evt_cnt increments on every edge that sets wrap_p.
  - It saturates at 16'hFFFF.
  - It is cleared by clr and by reset_n. load does not affect it.
- Not defined: evt_cnt is tied to 16'h0000, no event counter register is built, and all other behaviour is identical.

Test Plan:
- Reset and release: WIDTH=4, MOD_VAL=10, INIT_VAL=3. Assert reset_n=0 mid-count -> count becomes 3 immediately, without a clock edge. Release, hold en=0 for 5 cycles -> count stays 3, pulses stay 0.
- Up-count wrap: en=1, up_dn=1, sat_mode=0 from count=0 for 12 cycles -> count runs 1..9, 0, 1, 2. wrap_p is high only on the edge where count goes 9->0. With the macro defined, evt_cnt = 1.
- Down-count saturate: load load_val=2, then en=1, up_dn=0, sat_mode=1 for 4 cycles -> count 1, 0, 0, 0. sat_p is high on the 3rd and 4th edges; wrap_p stays 0.
- Load clamp: load=1, load_val=4'hE with MOD_VAL=10 -> count = 9 and at_max = 1. Same edge with en=1 -> load wins, no pulse.
- Priority: clr=1, load=1, en=1 together at count=7 -> count = INIT_VAL (3), pulses 0. With the macro defined, evt_cnt = 0.
- Full-range wrap: WIDTH=4, MOD_VAL=16, down-count from 0 -> count = 15 and wrap_p = 1. With the macro defined, 65540 wraps -> evt_cnt = 16'hFFFF.

Source files
------------

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with wrap/saturate, flags and event pulses; optional COUNTER_EVT_CNT_EN
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter longint unsigned  MOD_VAL  = 16,
    parameter longint unsigned  INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap_p,
    output logic             sat_p,
    output logic [15:0]      evt_cnt
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 2..32");
    end
    if (MOD_VAL < 2 || MOD_VAL > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("param_updown_counter: MOD_VAL must be 2..2**WIDTH");
    end
    if (INIT_VAL >= MOD_VAL) begin : g_bad_init
        $error("param_updown_counter: INIT_VAL must be below MOD_VAL");
    end

    // Limit is compared at WIDTH bits so MOD_VAL == 2**WIDTH gives all-ones.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VAL - 64'd1);
    localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        sat_nxt   = 1'b0;
        if (clr) begin
            count_nxt = INIT_W;
        end else if (load) begin
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count != MAX_VAL) begin
                    count_nxt = count + 1'b1;
                end else if (sat_mode) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_nxt = count - 1'b1;
                end else if (sat_mode) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= INIT_W;
            wrap_p <= 1'b0;
            sat_p  <= 1'b0;
        end else begin
            count  <= count_nxt;
            wrap_p <= wrap_nxt;
            sat_p  <= sat_nxt;
        end
    end

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);

`ifdef COUNTER_EVT_CNT_EN
    logic [15:0] evt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= 16'h0000;
        end else if (clr) begin
            evt_q <= 16'h0000;
        end else if (wrap_nxt && (evt_q != 16'hFFFF)) begin
            evt_q <= evt_q + 16'h0001;
        end
    end

    assign evt_cnt = evt_q;
`else
    assign evt_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - randomized self-checking bench for param_updown_counter (MOD 10 and full-range MOD 16 instances)
module tb_param_updown_counter;

`ifdef COUNTER_EVT_CNT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       sat_mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;

    logic [3:0]  count_a, count_b;
    logic        at_max_a, at_max_b, at_zero_a, at_zero_b;
    logic        wrap_a, wrap_b, sat_a, sat_b;
    logic [15:0] evt_a, evt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: a = MOD 10 / INIT 3, b = MOD 16 / INIT 0
    int mc_a, mw_a, ms_a, me_a;
    int mc_b, mw_b, ms_b, me_b;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .INIT_VAL(3)) dut_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .up_dn(up_dn),
        .sat_mode(sat_mode), .load(load), .load_val(load_val),
        .count(count_a), .at_max(at_max_a), .at_zero(at_zero_a),
        .wrap_p(wrap_a), .sat_p(sat_a), .evt_cnt(evt_a)
    );

    param_updown_counter #(.WIDTH(4), .MOD_VAL(16), .INIT_VAL(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .up_dn(up_dn),
        .sat_mode(sat_mode), .load(load), .load_val(load_val),
        .count(count_b), .at_max(at_max_b), .at_zero(at_zero_b),
        .wrap_p(wrap_b), .sat_p(sat_b), .evt_cnt(evt_b)
    );

    task automatic model_update(input int modv, input int initv,
                                inout int c, inout int w, inout int s, inout int e);
        int t;
        w = 0;
        s = 0;
        if (clr) begin
            c = initv;
            e = 0;
        end else if (load) begin
            c = (int'(load_val) < modv) ? int'(load_val) : modv - 1;
        end else if (en) begin
            t = up_dn ? c + 1 : c - 1;
            if (t >= 0 && t < modv) begin
                c = t;
            end else if (sat_mode) begin
                s = 1;
            end else begin
                c = (t + modv) % modv;
                w = 1;
                if (EVT_ON && e < 65535) e = e + 1;
            end
        end
    endtask

    task automatic step(input logic c_, input logic l_, input logic [3:0] lv,
                        input logic e_, input logic u_, input logic s_);
        clr = c_; load = l_; load_val = lv; en = e_; up_dn = u_; sat_mode = s_;
        @(posedge clk);
        model_update(10, 3, mc_a, mw_a, ms_a, me_a);
        model_update(16, 0, mc_b, mw_b, ms_b, me_b);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        mc_a = 3; mw_a = 0; ms_a = 0; me_a = 0;
        mc_b = 0; mw_b = 0; ms_b = 0; me_b = 0;
        n_cmp++;
        if (count_a !== 4'd3 || count_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset_async: count_a=%0d count_b=%0d want 3/0", count_a, count_b);
        end
        n_cmp++;
        if ({wrap_a, sat_a, wrap_b, sat_b} !== 4'b0 || evt_a !== 16'h0 || evt_b !== 16'h0) begin
            n_err++;
            $display("FAIL reset_flags: pulses=%b evt=%h/%h want 0", {wrap_a, sat_a, wrap_b, sat_b}, evt_a, evt_b);
        end
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
            n_cmp++;
            if (count_a !== 4'd3 || wrap_a !== 1'b0 || sat_a !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: count=%0d wrap=%b sat=%b want 3/0/0", i, count_a, wrap_a, sat_a);
            end
        end
    endtask

    task automatic test_up_wrap;
        int ev0;
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
        ev0 = int'(evt_a);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (int'(count_a) !== (i + 1) % 10 || wrap_a !== (i == 9) || sat_a !== 1'b0) begin
                n_err++;
                $display("FAIL up_wrap[%0d]: count=%0d wrap=%b sat=%b want %0d/%b/0", i, count_a, wrap_a, sat_a, (i + 1) % 10, (i == 9));
            end
        end
        n_cmp++;
        if (int'(evt_a) !== ev0 + (EVT_ON ? 1 : 0)) begin
            n_err++;
            $display("FAIL up_wrap_evt: evt=%0d want %0d", evt_a, ev0 + (EVT_ON ? 1 : 0));
        end
    endtask

    task automatic test_down_sat;
        int exp_c[4] = '{1, 0, 0, 0};
        step(1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (int'(count_a) !== exp_c[i] || sat_a !== (i >= 2) || wrap_a !== 1'b0 || at_zero_a !== (exp_c[i] == 0)) begin
                n_err++;
                $display("FAIL down_sat[%0d]: count=%0d sat=%b wrap=%b zero=%b want %0d/%b/0", i, count_a, sat_a, wrap_a, at_zero_a, exp_c[i], (i >= 2));
            end
        end
    endtask

    task automatic test_load_clamp;
        step(1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (count_a !== 4'd9 || at_max_a !== 1'b1 || wrap_a !== 1'b0 || sat_a !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: count=%0d at_max=%b wrap=%b sat=%b want 9/1/0/0", count_a, at_max_a, wrap_a, sat_a);
        end
        n_cmp++;
        if (count_b !== 4'hE || at_max_b !== 1'b0) begin
            n_err++;
            $display("FAIL load_noclamp16: count=%0d at_max=%b want 14/0", count_b, at_max_b);
        end
    endtask

    task automatic test_priority;
        step(1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (count_a !== 4'd7) begin
            n_err++;
            $display("FAIL prio_setup: count=%0d want 7", count_a);
        end
        step(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (count_a !== 4'd3 || count_b !== 4'd0 || {wrap_a, sat_a} !== 2'b00 || evt_a !== 16'h0 || evt_b !== 16'h0) begin
            n_err++;
            $display("FAIL priority: count=%0d/%0d pulses=%b evt=%h/%h want 3/0/00/0/0", count_a, count_b, {wrap_a, sat_a}, evt_a, evt_b);
        end
    endtask

    task automatic test_full_range;
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (count_b !== 4'd15 || wrap_b !== 1'b1 || sat_b !== 1'b0 || at_max_b !== 1'b1) begin
            n_err++;
            $display("FAIL full_wrap: count=%0d wrap=%b sat=%b at_max=%b want 15/1/0/1", count_b, wrap_b, sat_b, at_max_b);
        end
`ifdef COUNTER_EVT_CNT_EN
        // Alternating direction at the limits makes every edge a wrap for dut_b.
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1, (mc_b == 15), 1'b0);
        end
        n_cmp++;
        if (evt_b !== 16'hFFFF || int'(evt_b) !== me_b) begin
            n_err++;
            $display("FAIL evt_saturate: evt=%h want FFFF (model %h)", evt_b, me_b);
        end
`endif
    endtask

    task automatic test_random;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 4'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
            n_cmp++;
            if (int'(count_a) !== mc_a || int'(wrap_a) !== mw_a || int'(sat_a) !== ms_a || int'(evt_a) !== me_a ||
                at_max_a !== (mc_a == 9) || at_zero_a !== (mc_a == 0) ||
                int'(count_b) !== mc_b || int'(wrap_b) !== mw_b || int'(sat_b) !== ms_b || int'(evt_b) !== me_b ||
                at_max_b !== (mc_b == 15) || at_zero_b !== (mc_b == 0)) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random[%0d]: a=%0d/%b/%b/%0d b=%0d/%b/%b/%0d want a=%0d/%0d/%0d/%0d b=%0d/%0d/%0d/%0d",
                             i, count_a, wrap_a, sat_a, evt_a, count_b, wrap_b, sat_b, evt_b,
                             mc_a, mw_a, ms_a, me_a, mc_b, mw_b, ms_b, me_b);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_priority();
        test_full_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
